// File: rtl/lpc_pkg.sv
// Shared constants and types for the LPC filter sequencer.
package lpc_pkg;

  localparam int LPC_FRAME_LEN = 160;
  localparam int LPC_ORDER     = 10;

  // tap_src encodings
  localparam logic [1:0] SRC_IN   = 2'd0;
  localparam logic [1:0] SRC_OUT  = 2'd1;
  localparam logic [1:0] SRC_HIST = 2'd2;

  // mode encodings
  localparam logic MODE_ANALYSIS = 1'b0;
  localparam logic MODE_SYNTH    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lpc_state_e;

endpackage

// File: rtl/lpc_tap_counter.sv
// Sample/tap counter pair. k runs 0..K(n) for each sample n, where K(n) is
// ORDER with history carry-over, otherwise min(n, ORDER).
module lpc_tap_counter #(
  parameter int FRAME_LEN = 160,
  parameter int ORDER     = 10,
  parameter int ADDR_W    = 8,
  parameter int TAP_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              carry,
  output logic [ADDR_W-1:0] n,
  output logic [TAP_W-1:0]  k,
  output logic              last_tap
);

  logic [TAP_W-1:0] k_lim;

  // Tap limit for the current sample; early samples are truncated without carry.
  always_comb begin
    k_lim = TAP_W'(ORDER);
    if (!carry && (n < ADDR_W'(ORDER))) begin
      k_lim = TAP_W'(n);
    end
  end

  assign last_tap = (k == k_lim);

  // Advance k, rolling into the next sample after the last tap; n wraps at frame end.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      n <= '0;
      k <= '0;
    end else if (en) begin
      if (last_tap) begin
        k <= '0;
        n <= (n == ADDR_W'(FRAME_LEN - 1)) ? '0 : n + ADDR_W'(1);
      end else begin
        k <= k + TAP_W'(1);
      end
    end
  end

endmodule

// File: rtl/lpc_filter_control.sv
// Frame sequencer for the single-MAC LPC analysis/synthesis datapath.
//
//   state | meaning
//   IDLE  | waiting for start; all strobes low
//   RUN   | one tap per cycle over the frame, stall freezes
//   DONE  | one-cycle done pulse, then back to IDLE
module lpc_filter_control
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ORDER     = LPC_ORDER,
  parameter int ADDR_W    = 8,
  parameter int TAP_W     = 4,
  parameter int HIST_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              carry,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              acc_clear,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [ORDER-1:0]  a_rsel,
  output logic [ADDR_W-1:0] in_raddr,
  output logic [ADDR_W-1:0] tap_raddr,
  output logic [1:0]        tap_src,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_wen,
  output logic              hist_wen,
  output logic [HIST_W-1:0] hist_waddr
);

  lpc_state_e        state;
  logic              mode_q;
  logic              carry_q;
  logic [ADDR_W-1:0] n;
  logic [TAP_W-1:0]  k;
  logic              last_tap;
  logic              running;
  logic              step;
  logic              frame_end;
  logic [ADDR_W-1:0] k_ext;
  logic              tap_wraps;
  logic              hist_zone;

  assign running   = (state == RUN);
  assign step      = running && !stall;
  assign frame_end = step && last_tap && (n == ADDR_W'(FRAME_LEN - 1));

  lpc_tap_counter #(
    .FRAME_LEN (FRAME_LEN),
    .ORDER     (ORDER),
    .ADDR_W    (ADDR_W),
    .TAP_W     (TAP_W)
  ) u_tap_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (!running),
    .en       (step),
    .carry    (carry_q),
    .n        (n),
    .k        (k),
    .last_tap (last_tap)
  );

  // Frame FSM; mode and carry are captured only when a frame is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= MODE_ANALYSIS;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            mode_q  <= mode;
            carry_q <= carry;
          end
        end
        RUN: begin
          if (frame_end) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign k_ext     = ADDR_W'(k);
  assign tap_wraps = (n < k_ext);
  assign hist_zone = (n >= ADDR_W'(FRAME_LEN - ORDER));

  // Datapath control decoded from the registered state and counters.
  always_comb begin
    busy       = running;
    done       = (state == DONE);
    acc_clear  = running && (k == '0);
    tap_idx    = running ? k : '0;
    a_rsel     = '0;
    in_raddr   = running ? n : '0;
    out_waddr  = running ? n : '0;
    tap_raddr  = '0;
    tap_src    = SRC_IN;
    out_wen    = step && last_tap;
    hist_wen   = step && last_tap && hist_zone;
    hist_waddr = '0;
    if (running) begin
      // Negative sample offsets index the history file, oldest entry at 0.
      tap_raddr = tap_wraps ? (ADDR_W'(ORDER) + n - k_ext) : (n - k_ext);
      if (k != '0) begin
        a_rsel = ORDER'(1) << (k - TAP_W'(1));
        if (tap_wraps) begin
          tap_src = SRC_HIST;
        end else if (mode_q == MODE_SYNTH) begin
          tap_src = SRC_OUT;
        end
      end
      if (hist_zone) begin
        hist_waddr = HIST_W'(n - ADDR_W'(FRAME_LEN - ORDER));
      end
    end
  end

endmodule

// File: tb/tb_lpc_filter_control.sv
// Directed bench for lpc_filter_control with default parameters.
module tb_lpc_filter_control;

  logic       clk = 1'b0;
  logic       reset, start, mode, carry, stall;
  logic       busy, done, acc_clear, out_wen, hist_wen;
  logic [3:0] tap_idx, hist_waddr;
  logic [9:0] a_rsel;
  logic [7:0] in_raddr, tap_raddr, out_waddr;
  logic [1:0] tap_src;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] n_in;
    logic [7:0] ow;
    logic [3:0] k;
    logic [7:0] raddr;
    logic [1:0] src;
    logic [9:0] rsel;
    logic       acc;
    logic       wen;
    logic       hwen;
    logic [3:0] hwa;
    logic       stl;
  } rec_t;

  rec_t trace[$];
  int   run_cycles, wen_cnt, hwen_cnt, stall_run, wen_in_stall, done_t;
  logic busy_after_done;

  lpc_filter_control dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .carry      (carry),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .acc_clear  (acc_clear),
    .tap_idx    (tap_idx),
    .a_rsel     (a_rsel),
    .in_raddr   (in_raddr),
    .tap_raddr  (tap_raddr),
    .tap_src    (tap_src),
    .out_waddr  (out_waddr),
    .out_wen    (out_wen),
    .hist_wen   (hist_wen),
    .hist_waddr (hist_waddr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame, recording every RUN cycle; start is also pulsed in DONE.
  task automatic run_frame(input bit m, input bit c, input int stall_pct, input bit poke);
    rec_t r;
    trace.delete();
    run_cycles = 0; wen_cnt = 0; hwen_cnt = 0; stall_run = 0; wen_in_stall = 0;
    done_t = -1; busy_after_done = 1'bx;
    mode = m; carry = c; stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 6000; t++) begin
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        carry = 1'($urandom_range(0, 1));
      end
      stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
      #1;
      if (done) begin
        done_t = t;
        stall  = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        busy_after_done = busy;
        break;
      end
      if (busy) begin
        r.n_in = in_raddr; r.ow = out_waddr; r.k = tap_idx; r.raddr = tap_raddr;
        r.src = tap_src; r.rsel = a_rsel; r.acc = acc_clear; r.wen = out_wen;
        r.hwen = hist_wen; r.hwa = hist_waddr; r.stl = stall;
        trace.push_back(r);
        run_cycles++;
        if (stall) stall_run++;
        if (stall && (out_wen || hist_wen)) wen_in_stall++;
        if (out_wen) wen_cnt++;
        if (hist_wen) hwen_cnt++;
      end
      tick();
    end
    stall = 1'b0; start = 1'b0; mode = m; carry = c;
  endtask

  // Index of the first trace entry that departs from the expected tap walk, or -1.
  function automatic int trace_mismatch(bit m, bit c);
    int n = 0, k = 0, kl;
    logic [7:0] e_raddr;
    logic [1:0] e_src;
    logic [9:0] e_rsel;
    logic e_wen, e_hwen;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i].stl) begin
        if (i + 1 >= trace.size()) return i;
        if (trace[i].n_in !== trace[i+1].n_in || trace[i].k !== trace[i+1].k ||
            trace[i].raddr !== trace[i+1].raddr || trace[i].src !== trace[i+1].src ||
            trace[i].rsel !== trace[i+1].rsel || trace[i].ow !== trace[i+1].ow ||
            trace[i].wen !== 1'b0 || trace[i].hwen !== 1'b0) return i;
        continue;
      end
      if (n >= 160) return i;
      kl      = c ? 10 : ((n < 10) ? n : 10);
      e_raddr = (n >= k) ? 8'(n - k) : 8'(10 + n - k);
      e_src   = (k == 0) ? 2'd0 : ((n < k) ? 2'd2 : (m ? 2'd1 : 2'd0));
      e_rsel  = (k == 0) ? 10'd0 : (10'd1 << (k - 1));
      e_wen   = (k == kl);
      e_hwen  = e_wen && (n >= 150);
      if (trace[i].n_in !== 8'(n) || trace[i].ow !== 8'(n) || trace[i].k !== 4'(k) ||
          trace[i].raddr !== e_raddr || trace[i].src !== e_src || trace[i].rsel !== e_rsel ||
          trace[i].acc !== (k == 0) || trace[i].wen !== e_wen || trace[i].hwen !== e_hwen ||
          (e_hwen && trace[i].hwa !== 4'(n - 150))) return i;
      if (k == kl) begin k = 0; n++; end
      else k++;
    end
    if (n != 160) return trace.size();
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; carry = 1'b0; stall = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, acc_clear, out_wen, hist_wen} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, acc_clear, out_wen, hist_wen});
    end
    checks++;
    if ({tap_idx, a_rsel, in_raddr, tap_raddr, tap_src, out_waddr, hist_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_addr: tap_idx=%0d a_rsel=%h in=%0d tap=%0d src=%0d out=%0d hist=%0d required all 0",
               tap_idx, a_rsel, in_raddr, tap_raddr, tap_src, out_waddr, hist_waddr);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_analysis();
    int cnt = 0, bad = 0, mm;
    logic [7:0] exp_ra [4];
    logic [9:0] exp_rs [4];
    exp_ra = '{8'd3, 8'd2, 8'd1, 8'd0};
    exp_rs = '{10'h000, 10'h001, 10'h002, 10'h004};
    run_frame(1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (run_cycles !== 1705) begin failures++; $display("FAIL ana_run_len: got %0d required 1705", run_cycles); end
    checks++;
    if (wen_cnt !== 160) begin failures++; $display("FAIL ana_wen_count: got %0d required 160", wen_cnt); end
    checks++;
    if (hwen_cnt !== 10) begin failures++; $display("FAIL ana_hwen_count: got %0d required 10", hwen_cnt); end
    checks++;
    if (done_t !== 1706) begin failures++; $display("FAIL ana_done_time: got %0d required 1706", done_t); end
    checks++;
    if (busy_after_done !== 1'b0) begin failures++; $display("FAIL start_in_done: busy=%b required 0", busy_after_done); end
    foreach (trace[i]) begin
      if (trace[i].n_in == 8'd3) begin
        if (cnt < 4 && (trace[i].raddr !== exp_ra[cnt] || trace[i].rsel !== exp_rs[cnt])) bad++;
        cnt++;
      end
    end
    checks++;
    if (cnt !== 4 || bad !== 0) begin
      failures++;
      $display("FAIL ana_n3_taps: taps=%0d wrong=%0d required 4 taps 0 wrong", cnt, bad);
    end
    mm = trace_mismatch(1'b0, 1'b0);
    checks++;
    if (mm !== -1) begin failures++; $display("FAIL ana_sequence: first bad index %0d required -1", mm); end
  endtask

  task automatic test_carry();
    int cnt = 0, bad = 0, found = 0, mm;
    run_frame(1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (run_cycles !== 1760) begin failures++; $display("FAIL carry_run_len: got %0d required 1760", run_cycles); end
    foreach (trace[i]) begin
      if (trace[i].n_in == 8'd0) begin
        cnt++;
        if (trace[i].k != 4'd0 && (trace[i].src !== 2'd2 || trace[i].raddr !== 8'(10 - int'(trace[i].k)))) bad++;
      end
      if (trace[i].n_in == 8'd12 && trace[i].k == 4'd10) begin
        found++;
        if (trace[i].src !== 2'd0 || trace[i].raddr !== 8'd2) bad++;
      end
    end
    checks++;
    if (cnt !== 11 || found !== 1 || bad !== 0) begin
      failures++;
      $display("FAIL carry_hist_taps: n0_taps=%0d n12k10=%0d wrong=%0d required 11 1 0", cnt, found, bad);
    end
    mm = trace_mismatch(1'b0, 1'b1);
    checks++;
    if (mm !== -1) begin failures++; $display("FAIL carry_sequence: first bad index %0d required -1", mm); end
  endtask

  task automatic test_synth();
    int j = 0, bad = 0, mm;
    run_frame(1'b1, 1'b0, 0, 1'b0);
    foreach (trace[i]) begin
      if (trace[i].n_in == 8'd20 && trace[i].k == 4'd3 && trace[i].src !== 2'd1) bad++;
      if (trace[i].n_in == 8'd20 && trace[i].k == 4'd0 && trace[i].src !== 2'd0) bad++;
      if (trace[i].hwen) begin
        if (trace[i].n_in !== 8'(150 + j) || trace[i].hwa !== 4'(j)) bad++;
        j++;
      end
    end
    checks++;
    if (j !== 10 || bad !== 0) begin
      failures++;
      $display("FAIL synth_src_hist: hist_writes=%0d wrong=%0d required 10 0", j, bad);
    end
    mm = trace_mismatch(1'b1, 1'b0);
    checks++;
    if (mm !== -1) begin failures++; $display("FAIL synth_sequence: first bad index %0d required -1", mm); end
  endtask

  task automatic test_stall();
    int mm;
    run_frame(1'b0, 1'b0, 30, 1'b0);
    checks++;
    if (wen_in_stall !== 0) begin failures++; $display("FAIL stall_wen: got %0d writes under stall required 0", wen_in_stall); end
    checks++;
    if (run_cycles !== 1705 + stall_run) begin
      failures++;
      $display("FAIL stall_run_len: got %0d required %0d", run_cycles, 1705 + stall_run);
    end
    checks++;
    if (done_t !== 1706 + stall_run) begin
      failures++;
      $display("FAIL stall_done_time: got %0d required %0d", done_t, 1706 + stall_run);
    end
    mm = trace_mismatch(1'b0, 1'b0);
    checks++;
    if (mm !== -1) begin failures++; $display("FAIL stall_sequence: first bad index %0d required -1", mm); end
  endtask

  task automatic test_mid_frame_inputs();
    int mm;
    run_frame(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (run_cycles !== 1705) begin failures++; $display("FAIL poke_run_len: got %0d required 1705", run_cycles); end
    mm = trace_mismatch(1'b1, 1'b0);
    checks++;
    if (mm !== -1) begin failures++; $display("FAIL poke_sequence: first bad index %0d required -1", mm); end
    checks++;
    if (busy_after_done !== 1'b0) begin failures++; $display("FAIL poke_start_in_done: busy=%b required 0", busy_after_done); end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0, reached = 0;
    mode = 1'b0; carry = 1'b0; stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (busy && in_raddr == 8'd80) begin reached = 1; break; end
      tick();
    end
    checks++;
    if (reached !== 1) begin failures++; $display("FAIL rst_reach_n80: got %0d required 1", reached); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, acc_clear, out_wen, hist_wen, tap_idx, a_rsel, in_raddr, tap_raddr,
         tap_src, out_waddr, hist_waddr} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b acc=%b wen=%b hwen=%b k=%0d rsel=%h in=%0d tap=%0d src=%0d required all 0",
               busy, done, acc_clear, out_wen, hist_wen, tap_idx, a_rsel, in_raddr, tap_raddr, tap_src);
    end
    for (int t = 0; t < 30; t++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_no_done: got %0d busy/done cycles required 0", seen); end
    run_frame(1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (run_cycles !== 1705 || done_t !== 1706) begin
      failures++;
      $display("FAIL rst_restart: run=%0d done_at=%0d required 1705 1706", run_cycles, done_t);
    end
  endtask

  initial begin
    test_reset();
    test_analysis();
    test_carry();
    test_synth();
    test_stall();
    test_mid_frame_inputs();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
